// File: rtl/led_pio_write_arbiter_if.sv
// Requester handshakes, heartbeat enable and Avalon-MM LED PIO write port
// for led_pio_write_arbiter, bundled as one interface.
interface led_pio_write_arbiter_if #(
    parameter int DATA_W = 10
);
    logic              req0_valid;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              hb_enable;
    logic [1:0]        avm_address;
    logic              avm_chipselect;
    logic              avm_write_n;
    logic [31:0]       avm_writedata;
    logic [DATA_W-1:0] led_shadow;
    logic              busy;

    modport master (
        input  req0_valid, req0_data, req1_valid, req1_data, hb_enable,
        output req0_ready, req1_ready, avm_address, avm_chipselect,
        avm_write_n, avm_writedata, led_shadow, busy
    );

    modport slave (
        output req0_valid, req0_data, req1_valid, req1_data, hb_enable,
        input  req0_ready, req1_ready, avm_address, avm_chipselect,
        avm_write_n, avm_writedata, led_shadow, busy
    );
endinterface

// File: rtl/led_pio_write_arbiter.sv
// Avalon-MM write master for the LED PIO: arbitrates two requesters plus an
// internal heartbeat bit, and keeps a shadow of the last value written.
module led_pio_write_arbiter #(
    parameter int DATA_W   = 10,
    parameter int TICK_DIV = 50000000,
    parameter int HB_BIT   = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    led_pio_write_arbiter_if.master  bus
);
    localparam int              CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic { S_IDLE, S_WRITE } state_t;
    typedef enum logic [1:0] { SRC_NONE, SRC_HB, SRC_REQ0, SRC_REQ1 } src_t;

    state_t            state_q, state_d;
    src_t              src;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] led_shadow_q;
    logic [DATA_W-1:0] req0_val, req1_val;
    logic [CNT_W-1:0]  hb_cnt_q;
    logic              hb_pending_q;
    logic              hb_state_q;
    logic              hb_wrap;
    logic              rr_q;  // 0: req0 wins a tie, 1: req1 wins a tie

    assign hb_wrap = bus.hb_enable && (hb_cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        wdata_d  = wdata_q;
        src      = SRC_NONE;
        req0_val = bus.req0_data;
        req1_val = bus.req1_data;
        if (bus.hb_enable) begin
            req0_val[HB_BIT] = hb_state_q;
            req1_val[HB_BIT] = hb_state_q;
        end
        case (state_q)
            S_IDLE: begin
                if (bus.hb_enable && hb_pending_q)
                    src = SRC_HB;
                else if (bus.req0_valid && bus.req1_valid)
                    src = rr_q ? SRC_REQ1 : SRC_REQ0;
                else if (bus.req0_valid)
                    src = SRC_REQ0;
                else if (bus.req1_valid)
                    src = SRC_REQ1;

                case (src)
                    SRC_HB: begin
                        wdata_d         = led_shadow_q;
                        wdata_d[HB_BIT] = ~hb_state_q;
                    end
                    SRC_REQ0: wdata_d = req0_val;
                    SRC_REQ1: wdata_d = req1_val;
                    default:  wdata_d = wdata_q;
                endcase
                if (src != SRC_NONE)
                    state_d = S_WRITE;
            end
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wdata_q      <= '0;
            led_shadow_q <= '0;
            hb_cnt_q     <= '0;
            hb_pending_q <= 1'b0;
            hb_state_q   <= 1'b0;
            rr_q         <= 1'b0;
        end else begin
            state_q <= state_d;
            wdata_q <= wdata_d;
            if (state_q == S_WRITE)
                led_shadow_q <= wdata_q;

            if (!bus.hb_enable) begin
                hb_cnt_q     <= '0;
                hb_pending_q <= 1'b0;
                hb_state_q   <= 1'b0;
            end else begin
                hb_cnt_q <= hb_wrap ? '0 : hb_cnt_q + CNT_W'(1);
                // A fresh wrap re-arms the tick even on the cycle a tick is served.
                if (hb_wrap)
                    hb_pending_q <= 1'b1;
                else if (src == SRC_HB)
                    hb_pending_q <= 1'b0;
                if (src == SRC_HB)
                    hb_state_q <= ~hb_state_q;
            end

            if (src == SRC_REQ0)
                rr_q <= 1'b1;
            else if (src == SRC_REQ1)
                rr_q <= 1'b0;
        end
    end

    assign bus.req0_ready     = (src == SRC_REQ0);
    assign bus.req1_ready     = (src == SRC_REQ1);
    assign bus.busy           = (state_q == S_WRITE);
    assign bus.avm_address    = '0;
    assign bus.avm_chipselect = (state_q == S_WRITE);
    assign bus.avm_write_n    = (state_q != S_WRITE);
    assign bus.avm_writedata  = (state_q == S_WRITE) ? 32'(wdata_q) : '0;
    assign bus.led_shadow     = led_shadow_q;
endmodule

// File: tb/tb_led_pio_write_arbiter.sv
// Bench for led_pio_write_arbiter: reference model feeds an expected-write
// queue drained by a bus monitor, plus directed scenarios and random traffic.
module tb_led_pio_write_arbiter;
    localparam int DATA_W   = 10;
    localparam int TICK_DIV = 4;
    localparam int HB_BIT   = 9;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    led_pio_write_arbiter_if #(.DATA_W(DATA_W)) bus ();

    led_pio_write_arbiter #(
        .DATA_W  (DATA_W),
        .TICK_DIV(TICK_DIV),
        .HB_BIT  (HB_BIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: what the LED port should be doing, cycle by cycle.
    int                m_cnt = 0;
    bit                m_pend = 0, m_hbs = 0, m_busy = 0, m_rr = 0;
    bit                m_acc0 = 0, m_acc1 = 0;
    logic [DATA_W-1:0] m_shadow = '0, m_wdata = '0;
    logic [31:0]       exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_ready(input int n);
        if (m_busy || (bus.hb_enable && m_pend)) return 1'b0;
        if (bus.req0_valid && bus.req1_valid) return (n == int'(m_rr));
        return (n == 0) ? bus.req0_valid : bus.req1_valid;
    endfunction

    initial forever begin
        bit wrap, hbg;
        int n;
        logic [DATA_W-1:0] d;
        @(posedge clk);
        m_acc0 = 0;
        m_acc1 = 0;
        if (reset) begin
            m_cnt = 0; m_pend = 0; m_hbs = 0; m_busy = 0; m_rr = 0;
            m_shadow = '0; m_wdata = '0;
            exp_q.delete();
        end else begin
            wrap = bus.hb_enable && (m_cnt == TICK_DIV - 1);
            hbg  = 0;
            n    = -1;
            d    = '0;
            if (m_busy) begin
                m_shadow = m_wdata;
                m_busy   = 0;
            end else if (bus.hb_enable && m_pend) begin
                hbg   = 1;
                m_hbs = ~m_hbs;
                d     = m_shadow;
                d[HB_BIT] = m_hbs;
            end else if (bus.req0_valid && bus.req1_valid) begin
                n = m_rr ? 1 : 0;
            end else if (bus.req0_valid) begin
                n = 0;
            end else if (bus.req1_valid) begin
                n = 1;
            end
            if (n >= 0) begin
                d = (n == 0) ? bus.req0_data : bus.req1_data;
                if (bus.hb_enable) d[HB_BIT] = m_hbs;
                m_rr = (n == 0);
                if (n == 0) m_acc0 = 1; else m_acc1 = 1;
            end
            if (hbg || n >= 0) begin
                m_wdata = d;
                m_busy  = 1;
                exp_q.push_back(32'(d));
            end
            if (!bus.hb_enable) begin
                m_cnt = 0; m_pend = 0; m_hbs = 0;
            end else begin
                if (hbg)  m_pend = 0;
                if (wrap) m_pend = 1;
                m_cnt = wrap ? 0 : m_cnt + 1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("req0_ready", 32'(bus.req0_ready), 32'(exp_ready(0)));
        chk("req1_ready", 32'(bus.req1_ready), 32'(exp_ready(1)));
        chk("busy", 32'(bus.busy), 32'(m_busy));
        chk("chipselect", 32'(bus.avm_chipselect), 32'(m_busy));
        chk("write_n", 32'(bus.avm_write_n), 32'(!m_busy));
        chk("address", 32'(bus.avm_address), 32'd0);
        chk("led_shadow", 32'(bus.led_shadow), 32'(m_shadow));
        if (bus.avm_chipselect && !bus.avm_write_n) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got 0x%0h, expected no write (t=%0t)",
                         bus.avm_writedata, $time);
            end else begin
                chk("writedata", bus.avm_writedata, exp_q.pop_front());
            end
        end else begin
            chk("idle_writedata", bus.avm_writedata, 32'd0);
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        logic [31:0] vals[3];
        int          at[3];
        int          got;
        bus.req0_valid = 0; bus.req0_data = '0;
        bus.req1_valid = 0; bus.req1_data = '0;
        bus.hb_enable  = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Idle after reset, heartbeat off: no bus activity.
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("t1_cs", 32'(bus.avm_chipselect), 32'd0);
        chk("t1_write_n", 32'(bus.avm_write_n), 32'd1);
        chk("t1_shadow", 32'(bus.led_shadow), 32'd0);

        // Single req0 transfer.
        @(posedge clk); #1 bus.req0_valid = 1; bus.req0_data = 10'h2A3;
        @(negedge clk);
        chk("t2_ready0", 32'(bus.req0_ready), 32'd1);
        @(posedge clk); #1 bus.req0_valid = 0;
        @(negedge clk);
        chk("t2_cs", 32'(bus.avm_chipselect), 32'd1);
        chk("t2_write_n", 32'(bus.avm_write_n), 32'd0);
        chk("t2_wdata", bus.avm_writedata, 32'h2A3);
        chk("t2_ready0_in_write", 32'(bus.req0_ready), 32'd0);
        @(negedge clk);
        chk("t2_shadow", 32'(bus.led_shadow), 32'h2A3);
        chk("t2_cs_after", 32'(bus.avm_chipselect), 32'd0);

        // Round-robin alternation with both requesters held valid.
        do_reset();
        bus.req0_valid = 1; bus.req0_data = 10'h001;
        bus.req1_valid = 1; bus.req1_data = 10'h002;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin
                chk("t3_ready0", 32'(bus.req0_ready), 32'((k % 4) == 0));
                chk("t3_ready1", 32'(bus.req1_ready), 32'((k % 4) == 2));
            end else begin
                chk("t3_wdata", bus.avm_writedata, ((k % 4) == 1) ? 32'h001 : 32'h002);
            end
        end
        @(posedge clk); #1 bus.req0_valid = 0; bus.req1_valid = 0;

        // Heartbeat alone: toggles bit 9 every TICK_DIV cycles.
        @(posedge clk); #1 reset = 1'b1; bus.hb_enable = 1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        got = 0;
        for (int c = 0; c < 30 && got < 3; c++) begin
            @(negedge clk);
            if (bus.avm_chipselect) begin
                vals[got] = bus.avm_writedata;
                at[got]   = c;
                got++;
            end
        end
        chk("t4_writes_seen", 32'(got), 32'd3);
        if (got == 3) begin
            chk("t4_wdata0", vals[0], 32'h200);
            chk("t4_wdata1", vals[1], 32'h000);
            chk("t4_wdata2", vals[2], 32'h200);
            chk("t4_period0", 32'(at[1] - at[0]), 32'(TICK_DIV));
            chk("t4_period1", 32'(at[2] - at[1]), 32'(TICK_DIV));
        end

        // Requester bit HB_BIT replaced by hb_state only while enabled.
        @(posedge clk); #1 bus.req1_valid = 1; bus.req1_data = 10'h000;
        @(negedge clk);
        chk("t5_ready1", 32'(bus.req1_ready), 32'd1);
        @(posedge clk); #1 bus.req1_valid = 0; bus.hb_enable = 0;
        @(negedge clk);
        chk("t5_wdata_hb", bus.avm_writedata, 32'h200);
        @(posedge clk); #1 bus.req1_valid = 1; bus.req1_data = 10'h000;
        @(negedge clk);
        chk("t5_ready1_off", 32'(bus.req1_ready), 32'd1);
        @(posedge clk); #1 bus.req1_valid = 0;
        @(negedge clk);
        chk("t5_wdata_nohb", bus.avm_writedata, 32'h000);

        // Reset landing on the WRITE cycle.
        @(posedge clk); #1 bus.req0_valid = 1; bus.req0_data = 10'h3FF;
        @(posedge clk); #1 bus.req0_valid = 0; reset = 1'b1;
        @(negedge clk);
        chk("t6_cs_in_write", 32'(bus.avm_chipselect), 32'd1);
        @(negedge clk);
        chk("t6_cs", 32'(bus.avm_chipselect), 32'd0);
        chk("t6_write_n", 32'(bus.avm_write_n), 32'd1);
        chk("t6_shadow", 32'(bus.led_shadow), 32'd0);
        chk("t6_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 199) == 0) bus.hb_enable = ~bus.hb_enable;
            if (m_acc0 || !bus.req0_valid) begin
                bus.req0_valid = ($urandom_range(0, 2) == 0);
                bus.req0_data  = DATA_W'($urandom);
            end
            if (m_acc1 || !bus.req1_valid) begin
                bus.req1_valid = ($urandom_range(0, 2) == 0);
                bus.req1_data  = DATA_W'($urandom);
            end
        end
        @(posedge clk); #1;
        reset = 0; bus.req0_valid = 0; bus.req1_valid = 0; bus.hb_enable = 0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
